sort_engine: RTL and testbench

- Self-contained bubble-sort engine: FSM controller plus datapath in one block.
- Sorts N words in place in an external single-port memory with asynchronous read and synchronous write.
- Adds over the previous split datapath/controller pair: parametrised address/data width, start/busy/done handshake, ascending/descending mode, signed/unsigned compare, early exit on a swap-free pass, and pass/swap statistics.
- Sits between the top-level control and the data memory.

---
 rtl/sort_engine.sv | 179 +++++++++++++++++
 tb/tb_sort_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : sort_engine
// Purpose  : In-place bubble sort of an external single-port memory, with
//            start/busy/done handshake, direction/sign options and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module sort_engine #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic                 dp_clk,
  input  logic                 dp_rst_n,
  input  logic                 start,
  input  logic [ADDRWIDTH:0]   d_n,
  input  logic                 descend,
  input  logic [DATAWIDTH-1:0] rdata,
  output logic [ADDRWIDTH-1:0] address,
  output logic [DATAWIDTH-1:0] wdata,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRWIDTH:0]   pass_count,
  output logic [DATAWIDTH-1:0] swap_count
);

  localparam int CW = ADDRWIDTH + 1;
  localparam logic [CW-1:0]        c_one      = CW'(1);
  localparam logic [CW-1:0]        c_two      = CW'(2);
  localparam logic [DATAWIDTH-1:0] c_swap_inc = DATAWIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CHK  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_CMP  = 4'd4,
    S_WR1  = 4'd5,
    S_WR2  = 4'd6,
    S_NEXT = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_n;
  logic [CW-1:0]        r_c;
  logic [CW-1:0]        r_d;
  logic                 r_desc;
  logic                 r_swapped;
  logic [DATAWIDTH-1:0] r_t1;
  logic [DATAWIDTH-1:0] r_t2;
  logic [CW-1:0]        r_pass;
  logic [DATAWIDTH-1:0] r_swapc;

  logic [CW-1:0] w_d1;
  logic [CW-1:0] w_limit;
  logic          w_more;
  logic          w_final;
  logic          w_gt;
  logic          w_lt;
  logic          w_swap;

  assign w_d1    = r_d + c_one;
  assign w_limit = r_n - c_one - r_c;
  assign w_more  = (w_d1 < w_limit);
  // A swap-free pass means the array is already ordered.
  assign w_final = !r_swapped || ((r_c + c_one) == (r_n - c_one));
  assign w_swap  = r_desc ? w_lt : w_gt;

  generate
    if (SIGNED_CMP != 0) begin : g_signed_cmp
      assign w_gt = ($signed(r_t1) > $signed(r_t2));
      assign w_lt = ($signed(r_t1) < $signed(r_t2));
    end else begin : g_unsigned_cmp
      assign w_gt = (r_t1 > r_t2);
      assign w_lt = (r_t1 < r_t2);
    end
  endgenerate

  always_ff @(posedge dp_clk or negedge dp_rst_n) begin
    if (!dp_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    address = '0;
    wdata   = '0;
    mem_we  = 1'b0;
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    case (r_state)
      S_IDLE: if (start) w_next = S_CHK;
      S_CHK:  w_next = (r_n < c_two) ? S_DONE : S_RD1;
      S_RD1: begin
        address = r_d[ADDRWIDTH-1:0];
        w_next  = S_RD2;
      end
      S_RD2: begin
        address = w_d1[ADDRWIDTH-1:0];
        w_next  = S_CMP;
      end
      S_CMP:  w_next = w_swap ? S_WR1 : S_NEXT;
      S_WR1: begin
        address = r_d[ADDRWIDTH-1:0];
        wdata   = r_t2;
        mem_we  = 1'b1;
        w_next  = S_WR2;
      end
      S_WR2: begin
        address = w_d1[ADDRWIDTH-1:0];
        wdata   = r_t1;
        mem_we  = 1'b1;
        w_next  = S_NEXT;
      end
      S_NEXT: w_next = (w_more || !w_final) ? S_RD1 : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge dp_clk or negedge dp_rst_n) begin
    if (!dp_rst_n) begin
      r_n       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_desc    <= 1'b0;
      r_swapped <= 1'b0;
      r_t1      <= '0;
      r_t2      <= '0;
      r_pass    <= '0;
      r_swapc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= d_n;
            r_desc  <= descend;
            r_pass  <= '0;
            r_swapc <= '0;
          end
        end
        S_CHK: begin
          r_c       <= '0;
          r_d       <= '0;
          r_swapped <= 1'b0;
        end
        S_RD1: r_t1 <= rdata;
        S_RD2: r_t2 <= rdata;
        S_CMP: begin
          if (w_swap) begin
            r_swapped <= 1'b1;
            if (r_swapc != '1) r_swapc <= r_swapc + c_swap_inc;
          end
        end
        S_NEXT: begin
          if (w_more) begin
            r_d <= w_d1;
          end else begin
            r_pass <= r_pass + c_one;
            if (!w_final) begin
              r_c       <= r_c + c_one;
              r_d       <= '0;
              r_swapped <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pass_count = r_pass;
  assign swap_count = r_swapc;

endmodule
`default_nettype wire

// File: tb/tb_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_engine
// Purpose  : Directed self-checking bench for sort_engine (32-bit unsigned
//            instance plus 8-bit signed/unsigned pair).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  // 32-bit unsigned instance
  logic        start = 1'b0;
  logic [8:0]  d_n = '0;
  logic        descend = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  address;
  logic [31:0] wdata;
  logic        mem_we, busy, done;
  logic [8:0]  pass_count;
  logic [31:0] swap_count;
  logic [31:0] mem [0:255];

  // 8-bit signed / unsigned instances share their stimulus
  logic        start8 = 1'b0;
  logic [4:0]  d_n8 = '0;
  logic [7:0]  rdata_s, rdata_u, wdata_s, wdata_u, swap_s, swap_u;
  logic [3:0]  addr_s, addr_u;
  logic        we_s, we_u, busy_s, busy_u, done_s, done_u;
  logic [4:0]  pass_s, pass_u;
  logic [7:0]  mem_s [0:15];
  logic [7:0]  mem_u [0:15];

  logic        ld_en = 1'b0;
  logic [7:0]  ld_a = '0;
  logic [31:0] ld_d = '0;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0, busy_cnt = 0, done_cnt = 0, eq_cnt = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  assign rdata   = mem[address];
  assign rdata_s = mem_s[addr_s];
  assign rdata_u = mem_u[addr_u];

  sort_engine #(.DATAWIDTH(32), .ADDRWIDTH(8), .SIGNED_CMP(0)) u_dut (
    .dp_clk(clk), .dp_rst_n(rst_n), .start(start), .d_n(d_n), .descend(descend),
    .rdata(rdata), .address(address), .wdata(wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .pass_count(pass_count), .swap_count(swap_count));

  sort_engine #(.DATAWIDTH(8), .ADDRWIDTH(4), .SIGNED_CMP(1)) u_s8 (
    .dp_clk(clk), .dp_rst_n(rst_n), .start(start8), .d_n(d_n8), .descend(1'b0),
    .rdata(rdata_s), .address(addr_s), .wdata(wdata_s), .mem_we(we_s),
    .busy(busy_s), .done(done_s), .pass_count(pass_s), .swap_count(swap_s));

  sort_engine #(.DATAWIDTH(8), .ADDRWIDTH(4), .SIGNED_CMP(0)) u_u8 (
    .dp_clk(clk), .dp_rst_n(rst_n), .start(start8), .d_n(d_n8), .descend(1'b0),
    .rdata(rdata_u), .address(addr_u), .wdata(wdata_u), .mem_we(we_u),
    .busy(busy_u), .done(done_u), .pass_count(pass_u), .swap_count(swap_u));

  // Memories plus activity monitor; an equal-valued write pair would be a swap of equal words.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_a]        <= ld_d;
      mem_s[ld_a[3:0]] <= ld_d[7:0];
      mem_u[ld_a[3:0]] <= ld_d[7:0];
    end else begin
      if (mem_we) mem[address] <= wdata;
      if (we_s)   mem_s[addr_s] <= wdata_s;
      if (we_u)   mem_u[addr_u] <= wdata_u;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
    if (mem_we && prev_we && address == prev_addr + 8'd1 && wdata == prev_wdata)
      eq_cnt <= eq_cnt + 1;
    prev_we    <= mem_we;
    prev_addr  <= address;
    prev_wdata <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Launch a sort on the 32-bit instance; k is the cycle (1 = CHK) in which done is seen.
  task automatic run_sort(input logic [8:0] n, input logic desc, input bit poke, output int k);
    @(negedge clk);
    d_n = n; descend = desc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
      if (poke && k == 3) begin start = 1'b1; d_n = 9'd0; end
      else if (poke && k == 4) begin start = 1'b0; d_n = n; end
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  int k, we0, busy0, done0, eq0;
  logic [31:0] exp_v [0:4];

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_pass", {23'd0, pass_count}, 32'd0);
    check("rst_swap", swap_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reverse order, ascending, with a start pulse while busy
    load(0, 4); load(1, 3); load(2, 2); load(3, 1);
    we0 = we_cnt; done0 = done_cnt; eq0 = eq_cnt;
    run_sort(9'd4, 1'b0, 1'b1, k);
    for (int i = 0; i < 4; i++) check("t1_mem", mem[i], 32'(i + 1));
    check("t1_pass", {23'd0, pass_count}, 32'd3);
    check("t1_swap", swap_count, 32'd6);
    check("t1_we", 32'(we_cnt - we0), 32'd12);
    check("t1_done", 32'(done_cnt - done0), 32'd1);
    check("t1_eq", 32'(eq_cnt - eq0), 32'd0);

    // Already sorted: one pass, early exit
    we0 = we_cnt; busy0 = busy_cnt;
    run_sort(9'd4, 1'b0, 1'b0, k);
    check("t2_lat", 32'(k), 32'd14);
    check("t2_busy", 32'(busy_cnt - busy0), 32'd14);
    check("t2_we", 32'(we_cnt - we0), 32'd0);
    check("t2_pass", {23'd0, pass_count}, 32'd1);
    check("t2_swap", swap_count, 32'd0);

    // Descending with duplicates
    load(0, 3); load(1, 1); load(2, 3); load(3, 0); load(4, 2);
    exp_v[0] = 3; exp_v[1] = 3; exp_v[2] = 2; exp_v[3] = 1; exp_v[4] = 0;
    eq0 = eq_cnt;
    run_sort(9'd5, 1'b1, 1'b0, k);
    for (int i = 0; i < 5; i++) check("t3_mem", mem[i], exp_v[i]);
    check("t3_swap", swap_count, 32'd3);
    check("t3_pass", {23'd0, pass_count}, 32'd3);
    check("t3_eq", 32'(eq_cnt - eq0), 32'd0);

    // Signed vs unsigned 8-bit compare
    load(0, 32'h05); load(1, 32'hFF); load(2, 32'h80);
    @(negedge clk);
    d_n8 = 5'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while ((busy_s || busy_u) && k < 200) begin @(negedge clk); k++; end
    check("t4_idle", {31'd0, busy_s | busy_u}, 32'd0);
    check("t4_s0", {24'd0, mem_s[0]}, 32'h80);
    check("t4_s1", {24'd0, mem_s[1]}, 32'hFF);
    check("t4_s2", {24'd0, mem_s[2]}, 32'h05);
    check("t4_u0", {24'd0, mem_u[0]}, 32'h05);
    check("t4_u1", {24'd0, mem_u[1]}, 32'h80);
    check("t4_u2", {24'd0, mem_u[2]}, 32'hFF);
    check("t4_sswap", {24'd0, swap_s}, 32'd3);
    check("t4_uswap", {24'd0, swap_u}, 32'd1);

    // Degenerate lengths
    for (int n = 0; n < 2; n++) begin
      we0 = we_cnt; busy0 = busy_cnt;
      run_sort(9'(n), 1'b0, 1'b0, k);
      check("t5_lat", 32'(k), 32'd2);
      check("t5_busy", 32'(busy_cnt - busy0), 32'd2);
      check("t5_we", 32'(we_cnt - we0), 32'd0);
      check("t5_pass", {23'd0, pass_count}, 32'd0);
    end

    // Asynchronous reset in WR1, then a clean re-sort
    load(0, 4); load(1, 3); load(2, 2); load(3, 1);
    @(negedge clk);
    d_n = 9'd4; descend = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!mem_we && k < 50) begin @(negedge clk); k++; end
    check("t6_wr1", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_we", {31'd0, mem_we}, 32'd0);
    check("t6_addr", {24'd0, address}, 32'd0);
    check("t6_wdata", wdata, 32'd0);
    check("t6_swap", swap_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sort(9'd4, 1'b0, 1'b0, k);
    for (int i = 0; i < 4; i++) check("t6_mem", mem[i], 32'(i + 1));
    check("t6_swap2", swap_count, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
